ram_rr_ctrl: RTL
================

// Module: ram_rr_ctrl
// PURPOSE
//  Two-requester round-robin controller for the 16x8 single-port RAM. It clears the RAM
//  after reset, then shares its one port between requesters A and B. Each requester uses
//  a valid/ready request channel and a one-cycle read-response pulse. It sits between the
//  client logic and the RAM's clk/valid/wr_rd/add/writedata/readdata port.
// PARAMETERS
//  ADDR_W          4    address width; DEPTH = 2**ADDR_W
//  DATA_W          8    data width
//  CLEAR_ON_RESET  1    1: zero-fill all RAM words after reset; 0: go straight to IDLE
// PORTS
//  clk              in   1       single clock, all logic on posedge
//  rst              in   1       synchronous reset, active-high
//  a_valid/b_valid  in   1       request present
//  a_wr_rd/b_wr_rd  in   1       1 = write, 0 = read
//  a_add/b_add      in   ADDR_W  request address
//  a_writedata/b_.. in   DATA_W  write data
//  a_ready/b_ready  out  1       request accepted this cycle (combinational)
//  a_rvalid/b_..    out  1       one-cycle read-data-valid pulse (registered)
//  a_readdata/b_..  out  DATA_W  read data, held until the next read response (registered)
//  mem_valid        out  1       RAM port access strobe
//  mem_wr_rd        out  1       RAM write (1) or read (0)
//  mem_add          out  ADDR_W  RAM address
//  mem_writedata    out  DATA_W  RAM write data
//  mem_readdata     in   DATA_W  RAM registered read data, valid 1 cycle after a read strobe
//  init_done        out  1       high once the clear sweep is finished
// BEHAVIOUR
//  - Reset (rst=1 at posedge) overrides everything.
//    Reset values: *_rvalid=0, *_readdata=0, clr_cnt=0, last_grant=B (A wins the first tie).
//    Next state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; init_done=0 in CLEAR.
//    A read pending at reset is dropped; no rvalid is issued for it.
//  - FSM states: CLEAR, IDLE, RD_RSP.
//  - CLEAR
//    - Drives mem_valid=1, mem_wr_rd=1, mem_writedata=0, mem_add=clr_cnt.
//    - clr_cnt increments each cycle. After address DEPTH-1 is written, FSM goes to IDLE.
//    - The sweep takes exactly DEPTH cycles. *_ready=0 throughout.
//  - IDLE
//    - Grant: if exactly one valid, grant it. If both valid, grant the one != last_grant.
//    - granted_ready=1, other ready=0. The mem_* outputs are a combinational mux of the
//      granted request; with no valid, mem_valid=0.
//    - On accept (valid&ready at posedge), last_grant <= granted requester.
//    - Write: completes at the accept edge; FSM stays in IDLE. One write/cycle is possible.
//    - Read: FSM -> RD_RSP; owner of the read is recorded.
//  - RD_RSP
//    - mem_valid=0; both ready=0.
//    - At the next posedge: owner_readdata <= mem_readdata, owner_rvalid <= 1, FSM -> IDLE.
//    - Read latency: rvalid is high in the 2nd cycle after the accept cycle.
//      Read throughput is one read per 2 cycles.
//  - *_rvalid deasserts after one cycle. *_readdata holds its value.
//  - Write-then-read to the same address in consecutive accepts returns the new data.
//  - Address is ADDR_W bits; no bounds check. Address DEPTH-1 is legal and the clear
//    sweep wraps clr_cnt to 0 after DEPTH-1.
//  - Requesters must hold valid and payload stable until ready. Dropping valid early
//    discards the request; it is not an error.
// STRUCTURE
//  - Package ram_ctrl_pkg: ADDR_W/DATA_W defaults, DEPTH constant, state enum
//    {CLEAR, IDLE, RD_RSP}, requester id constants REQ_A=0 and REQ_B=1.
//  - Sub-module rr_arb2: 2-way round-robin grant (inputs: req[1:0], last_grant;
//    output: one-hot gnt). Purely combinational; last_grant is registered in ram_rr_ctrl.
//  - Instantiate together with the 16x8 RAM in the bench; ram_rr_ctrl itself holds no storage.
// TESTING
//  - Reset, CLEAR_ON_RESET=1 -> mem_valid=1, wr_rd=1, data=0 for addresses 0..15 over
//    16 cycles; init_done rises after the sweep; every read afterwards returns 8'h00.
//  - A writes 8'h02 @1, then A reads @1 -> a_rvalid one pulse 2 cycles after accept,
//    a_readdata=8'h02; b_rvalid stays 0.
//  - A and B valid together for 4 reads (A @3 holds 8'h22, B @5 holds 8'h55) -> grants
//    alternate A,B,A,B; responses 8'h22/8'h55 reach the correct owner.
//  - Back-to-back writes from B to @15 then @0 (8'hF0, 8'h0F) -> accepted on consecutive
//    cycles; reads return F0/0F (covers address wrap boundary).
//  - rst asserted in RD_RSP -> no rvalid on either side; readdata=0; CLEAR restarts at
//    address 0.
//  - CLEAR_ON_RESET=0 -> init_done=1 and a_ready=1 in the first cycle after reset with
//    a_valid=1.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the two-requester round-robin RAM port controller.
// Provides default geometry, FSM state encodings and requester ids.
// Imported by rr_arb2 and ram_rr_ctrl.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  // FSM encodings kept as plain constants so older flows can consume them.
  typedef logic [1:0] state_t;
  localparam state_t ST_CLEAR  = 2'd0;
  localparam state_t ST_IDLE   = 2'd1;
  localparam state_t ST_RD_RSP = 2'd2;

  // Requester ids; bit position in req/gnt vectors matches the id.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: 2-way round-robin grant; the requester that did not win last time wins a tie.
// Latency: purely combinational. Backpressure: none; last_grant is owned by the caller.
// Ports: req[1:0] (bit0=A, bit1=B), last_grant (REQ_A/REQ_B), gnt[1:0] one-hot or zero.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_rr_ctrl.sv
// Purpose: clears the single-port RAM after reset, then shares it between requesters A and B.
// Latency: write completes at accept edge; read rvalid in the 2nd cycle after accept.
// Backpressure: *_ready is combinational; low during clear, read response, or lost arbitration.
// Ports: clk/rst (sync, active-high); a_*/b_* request channels with ready and rvalid/readdata
//        responses; mem_* drive the RAM port (mem_readdata returns one cycle after a read);
//        init_done is high once the clear sweep has finished.
module ram_rr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_wr_rd,
  input  logic [ADDR_W-1:0] a_add,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_readdata,
  input  logic              b_valid,
  input  logic              b_wr_rd,
  input  logic [ADDR_W-1:0] b_add,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_readdata,
  output logic              mem_valid,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   a_readdata_q, a_readdata_d;
  logic [DATA_W-1:0]   b_readdata_q, b_readdata_d;

  logic [1:0]          gnt;
  logic                sel_b;
  logic                sel_wr;

  rr_arb2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign sel_b  = gnt[1];
  assign sel_wr = sel_b ? b_wr_rd : a_wr_rd;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    a_readdata_d  = a_readdata_q;
    b_readdata_d  = b_readdata_q;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    mem_valid     = 1'b0;
    mem_wr_rd     = 1'b0;
    mem_add       = '0;
    mem_writedata = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_valid = 1'b1;
        mem_wr_rd = 1'b1;
        mem_add   = clr_cnt_q;
        // Counter wraps to 0 after the last word, so a later re-clear starts at 0.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        // A grant is only ever issued to a valid requester, so ready == accept here.
        a_ready       = gnt[0];
        b_ready       = gnt[1];
        mem_valid     = |gnt;
        mem_wr_rd     = sel_wr;
        mem_add       = sel_b ? b_add : a_add;
        mem_writedata = sel_b ? b_writedata : a_writedata;
        if (|gnt) begin
          last_grant_d = sel_b ? REQ_B : REQ_A;
          if (!sel_wr) begin
            owner_d = sel_b ? REQ_B : REQ_A;
            state_d = ST_RD_RSP;
          end
        end
      end

      ST_RD_RSP: begin
        // RAM output is valid during this cycle; capture it for the owner.
        state_d = ST_IDLE;
        if (owner_q == REQ_B) begin
          b_rvalid_d   = 1'b1;
          b_readdata_d = mem_readdata;
        end else begin
          a_rvalid_d   = 1'b1;
          a_readdata_d = mem_readdata;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= REQ_B;
      owner_q      <= REQ_A;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_readdata_q <= '0;
      b_readdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_readdata_q <= a_readdata_d;
      b_readdata_q <= b_readdata_d;
    end
  end

  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_readdata = a_readdata_q;
  assign b_readdata = b_readdata_q;
  assign init_done  = (state_q != ST_CLEAR);

endmodule
